rd_lat_stats: RTL and testbench

Latency statistics collector sitting directly downstream of the HBM read benchmark engine. It consumes the engine's per-read latency samples (`lat_timer`/`lat_timer_valid`), its execution-cycle count and its end-of-run pulse. It reduces them to count, min, max, sum and an optional 16-bin histogram, then holds the results stable for the host register readout.

---
 rtl/rd_lat_stats.sv | 123 ++++++++++++
 tb/tb_rd_lat_stats.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/rd_lat_stats.sv
// rtl/rd_lat_stats.sv - read-latency statistics collector (count/min/max/sum, optional histogram via RD_LAT_HIST_EN)
module rd_lat_stats #(
    parameter int LAT_WIDTH  = 16,
    parameter int CNT_WIDTH  = 32,
    parameter int SUM_WIDTH  = 48,
    parameter int HIST_SHIFT = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 lat_timer_valid,
    input  logic [LAT_WIDTH-1:0] lat_timer,
    input  logic [63:0]          lat_timer_sum,
    input  logic                 end_of_exec,
    output logic                 busy,
    output logic                 stats_valid,
    output logic                 stats_done,
    output logic [CNT_WIDTH-1:0] sample_cnt,
    output logic [LAT_WIDTH-1:0] lat_min,
    output logic [LAT_WIDTH-1:0] lat_max,
    output logic [SUM_WIDTH-1:0] lat_total,
    output logic [63:0]          exec_cycles,
    input  logic [3:0]           hist_rd_idx,
    output logic [CNT_WIDTH-1:0] hist_rd_data
);

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    state_t state;
    state_t state_next;

    logic [LAT_WIDTH-1:0] min_int;
    logic                 accept;
    logic [SUM_WIDTH:0]   total_add;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (start) begin
            state_next = COLLECT;
        end else begin
            case (state)
                COLLECT: if (end_of_exec) state_next = DONE;
                default: state_next = state;
            endcase
        end
    end

    assign busy        = (state == COLLECT);
    assign stats_valid = (state == DONE);
    assign accept      = (state == COLLECT) && !start && lat_timer_valid;
    assign total_add   = {1'b0, lat_total} + (SUM_WIDTH+1)'(lat_timer);

    // Internal min idles at all-ones so the first sample always wins; the
    // visible min is masked to 0 until something has been counted.
    assign lat_min = (sample_cnt == '0) ? '0 : min_int;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt  <= '0;
            min_int     <= '1;
            lat_max     <= '0;
            lat_total   <= '0;
            exec_cycles <= '0;
            stats_done  <= 1'b0;
        end else begin
            stats_done <= 1'b0;
            if (start) begin
                sample_cnt  <= '0;
                min_int     <= '1;
                lat_max     <= '0;
                lat_total   <= '0;
                exec_cycles <= '0;
            end else if (state == COLLECT) begin
                if (accept) begin
                    if (!(&sample_cnt)) sample_cnt <= sample_cnt + CNT_WIDTH'(1);
                    if (lat_timer < min_int) min_int <= lat_timer;
                    if (lat_timer > lat_max) lat_max <= lat_timer;
                    lat_total <= total_add[SUM_WIDTH] ? '1 : total_add[SUM_WIDTH-1:0];
                end
                if (end_of_exec) begin
                    exec_cycles <= lat_timer_sum;
                    stats_done  <= 1'b1;
                end
            end
        end
    end

`ifdef RD_LAT_HIST_EN
    logic [LAT_WIDTH-1:0] shifted;
    logic [3:0]           bin_idx;
    logic [CNT_WIDTH-1:0] bins [16];

    assign shifted = lat_timer >> HIST_SHIFT;
    assign bin_idx = (shifted > LAT_WIDTH'(15)) ? 4'd15 : shifted[3:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) bins[i] <= '0;
            hist_rd_data <= '0;
        end else begin
            hist_rd_data <= bins[hist_rd_idx];
            if (start) begin
                for (int i = 0; i < 16; i++) bins[i] <= '0;
            end else if (accept && !(&bins[bin_idx])) begin
                bins[bin_idx] <= bins[bin_idx] + CNT_WIDTH'(1);
            end
        end
    end
`else
    logic unused_hist;
    assign unused_hist  = ^hist_rd_idx;
    assign hist_rd_data = '0;
`endif

endmodule

// File: tb/tb_rd_lat_stats.sv
// tb/tb_rd_lat_stats.sv - scoreboard bench for rd_lat_stats (narrow counters so saturation is reachable)
module tb_rd_lat_stats;

    localparam int LW = 16;
    localparam int CW = 8;
    localparam int SW = 20;
`ifdef RD_LAT_HIST_EN
    localparam bit HIST = 1'b1;
`else
    localparam bit HIST = 1'b0;
`endif

    typedef struct {
        logic [CW-1:0] cnt;
        logic [LW-1:0] mn;
        logic [LW-1:0] mx;
        logic [SW-1:0] tot;
        logic [63:0]   ex;
    } stats_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          lat_timer_valid = 1'b0;
    logic [LW-1:0] lat_timer = '0;
    logic [63:0]   lat_timer_sum = '0;
    logic          end_of_exec = 1'b0;
    logic          busy, stats_valid, stats_done;
    logic [CW-1:0] sample_cnt;
    logic [LW-1:0] lat_min, lat_max;
    logic [SW-1:0] lat_total;
    logic [63:0]   exec_cycles;
    logic [3:0]    hist_rd_idx = '0;
    logic [CW-1:0] hist_rd_data;

    logic          rd_req = 1'b0;
    logic          rd_req_d = 1'b0;
    stats_t        exp_stats[$];
    logic [CW-1:0] exp_hist[$];
    int            total = 0;
    int            bad = 0;

    rd_lat_stats #(.LAT_WIDTH(LW), .CNT_WIDTH(CW), .SUM_WIDTH(SW), .HIST_SHIFT(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .lat_timer_valid(lat_timer_valid), .lat_timer(lat_timer),
        .lat_timer_sum(lat_timer_sum), .end_of_exec(end_of_exec),
        .busy(busy), .stats_valid(stats_valid), .stats_done(stats_done),
        .sample_cnt(sample_cnt), .lat_min(lat_min), .lat_max(lat_max),
        .lat_total(lat_total), .exec_cycles(exec_cycles),
        .hist_rd_idx(hist_rd_idx), .hist_rd_data(hist_rd_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rd_req_d <= rd_req;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT reports results or a bin read lands.
    always @(negedge clk) begin
        if (rst_n && stats_done) begin
            if (exp_stats.size() == 0) begin
                check("unexpected_stats_done", 64'd1, 64'd0);
            end else begin
                stats_t e;
                e = exp_stats.pop_front();
                check("stats_valid_at_done", {63'd0, stats_valid}, 64'd1);
                check("sample_cnt", {56'd0, sample_cnt}, {56'd0, e.cnt});
                check("lat_min", {48'd0, lat_min}, {48'd0, e.mn});
                check("lat_max", {48'd0, lat_max}, {48'd0, e.mx});
                check("lat_total", {44'd0, lat_total}, {44'd0, e.tot});
                check("exec_cycles", exec_cycles, e.ex);
            end
        end
        if (rst_n && rd_req_d) begin
            if (exp_hist.size() == 0) begin
                check("unexpected_hist_read", 64'd1, 64'd0);
            end else begin
                logic [CW-1:0] h;
                h = exp_hist.pop_front();
                check("hist_rd_data", {56'd0, hist_rd_data}, {56'd0, h});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic sample(input logic [LW-1:0] v);
        lat_timer_valid = 1'b1;
        lat_timer = v;
        tick();
        lat_timer_valid = 1'b0;
    endtask

    task automatic eoe(input logic [63:0] s);
        end_of_exec = 1'b1;
        lat_timer_sum = s;
        tick();
        end_of_exec = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!stats_valid && n < 20) begin
            tick();
            n++;
        end
        if (!stats_valid) check("wait_stats_valid_timeout", 64'd0, 64'd1);
    endtask

    task automatic hist_read(input logic [3:0] idx, input logic [CW-1:0] v);
        hist_rd_idx = idx;
        rd_req = 1'b1;
        exp_hist.push_back(HIST ? v : '0);
        tick();
        rd_req = 1'b0;
    endtask

    initial begin
        #12;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_stats_valid", {63'd0, stats_valid}, 64'd0);
        check("rst_sample_cnt", {56'd0, sample_cnt}, 64'd0);
        check("rst_lat_min", {48'd0, lat_min}, 64'd0);
        check("rst_exec_cycles", exec_cycles, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Basic run: 10, 3, 40
        exp_stats.push_back('{cnt: 3, mn: 3, mx: 40, tot: 53, ex: 500});
        do_start();
        check("busy_after_start", {63'd0, busy}, 64'd1);
        sample(10);
        check("cnt_one_cycle_latency", {56'd0, sample_cnt}, 64'd1);
        sample(3);
        sample(40);
        eoe(500);
        wait_done();
        check("stats_done_pulse_high", {63'd0, stats_done}, 64'd1);
        tick();
        check("stats_done_pulse_drops", {63'd0, stats_done}, 64'd0);
        check("stats_valid_holds", {63'd0, stats_valid}, 64'd1);

        // Throughput-mode run with no samples
        exp_stats.push_back('{cnt: 0, mn: 0, mx: 0, tot: 0, ex: 1234});
        do_start();
        tick();
        eoe(1234);
        wait_done();

        // Histogram binning and clamping
        exp_stats.push_back('{cnt: 6, mn: 0, mx: 65535, tot: 65669, ex: 77});
        do_start();
        sample(0); sample(3); sample(4); sample(63); sample(64); sample(16'hFFFF);
        eoe(77);
        wait_done();
        hist_read(4'd0, 8'd2);
        hist_read(4'd1, 8'd1);
        hist_read(4'd2, 8'd0);
        hist_read(4'd15, 8'd3);

        // Sample coincident with end_of_exec is counted; DONE ignores inputs
        exp_stats.push_back('{cnt: 2, mn: 7, mx: 9, tot: 16, ex: 999});
        do_start();
        sample(7);
        lat_timer_valid = 1'b1; lat_timer = 9; end_of_exec = 1'b1; lat_timer_sum = 999;
        tick();
        lat_timer_valid = 1'b0; end_of_exec = 1'b0;
        wait_done();
        tick();
        lat_timer_valid = 1'b1; lat_timer = 100; end_of_exec = 1'b1; lat_timer_sum = 5;
        tick();
        lat_timer_valid = 1'b0; end_of_exec = 1'b0;
        tick();
        check("done_ignores_sample", {56'd0, sample_cnt}, 64'd2);
        check("done_ignores_eoe", exec_cycles, 64'd999);
        check("done_no_repulse", {63'd0, stats_done}, 64'd0);
        do_start();
        check("start_in_done_busy", {63'd0, busy}, 64'd1);
        check("start_in_done_cleared", {56'd0, sample_cnt}, 64'd0);
        check("start_in_done_valid_low", {63'd0, stats_valid}, 64'd0);

        // Saturation: count, total and a bin all pin at all-ones
        exp_stats.push_back('{cnt: 8'hFF, mn: 16'hFFFF, mx: 16'hFFFF, tot: 20'hFFFFF, ex: 4242});
        do_start();
        for (int i = 0; i < 260; i++) sample(16'hFFFF);
        check("cnt_saturated", {56'd0, sample_cnt}, 64'hFF);
        eoe(4242);
        wait_done();
        hist_read(4'd15, 8'hFF);
        hist_read(4'd14, 8'd0);

        // Asynchronous reset mid-collection
        do_start();
        sample(20);
        sample(30);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", {63'd0, busy}, 64'd0);
        check("async_rst_cnt", {56'd0, sample_cnt}, 64'd0);
        check("async_rst_max", {48'd0, lat_max}, 64'd0);
        check("async_rst_total", {44'd0, lat_total}, 64'd0);
        check("async_rst_hist", {56'd0, hist_rd_data}, 64'd0);
        tick();
        check("async_rst_no_pulse", {63'd0, stats_done}, 64'd0);
        rst_n = 1'b1;
        tick();
        tick();

        check("stats_queue_drained", 64'(exp_stats.size()), 64'd0);
        check("hist_queue_drained", 64'(exp_hist.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
